uart_tx_arbiter: RTL

- Shares one UART transmitter between NUM_REQ byte-stream requesters, e.g. the CPU debug print port, the DMA engine and the trap reporter.
- Arbitrates round-robin at packet granularity: once granted, a requester owns the transmitter until it sends a byte with last set, or until it hits the MAX_PKT_BYTES fairness cap.
- Sits directly in front of the UART transmitter and drives its data_in / data_in_valid, observing its data_in_ready.

---
 rtl/uart_arb_pkg.sv | 31 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Also used by other round-robin arbiters in the codebase.
package uart_arb_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  localparam int GRANT_W = 3;
  localparam int BYTE_W  = 8;
  localparam int MAX_REQ = 8;

  // First set bit in mask, searching upward from ptr+1, wrapping at n.
  function automatic logic [GRANT_W:0] rr_next(
    input logic [MAX_REQ-1:0] mask,
    input logic [GRANT_W-1:0] ptr,
    input int                 n
  );
    logic [GRANT_W:0] res;
    int               j;
    res = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      j = (int'(ptr) + k) % n;
      if (k <= n && !res[GRANT_W] && mask[j[GRANT_W-1:0]])
        res = {1'b1, j[GRANT_W-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: mask + pointer -> index, found.
// Reusable by any port arbiter with up to MAX_REQ requesters.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]       mask,
  input  logic [GRANT_W-1:0] ptr,
  output logic [GRANT_W-1:0] idx,
  output logic               found
);

  logic [MAX_REQ-1:0] mask_pad;
  logic [GRANT_W:0]   pick;

  always_comb begin
    mask_pad        = '0;
    mask_pad[N-1:0] = mask;
    pick            = rr_next(mask_pad, ptr, N);
    idx             = pick[GRANT_W-1:0];
    found           = pick[GRANT_W];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of one UART transmitter.
// Define UART_ARB_TIMEOUT_EN to add the stall timeout and timeout_pulse.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MAX_PKT_BYTES  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      clear_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         uart_data,
  output logic                      uart_valid,
  input  logic                      uart_ready,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      busy
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                      timeout_pulse
`endif
);

  localparam int CNT_W = $clog2(MAX_PKT_BYTES + 1);

  arb_state_t state, state_n;

  logic [GRANT_W-1:0]        grant;
  logic [GRANT_W-1:0]        rr_ptr;
  logic [GRANT_W-1:0]        pick_idx;
  logic                      pick_found;
  logic [CNT_W-1:0]          byte_cnt;
  logic [MAX_REQ-1:0]        valid_pad;
  logic [MAX_REQ-1:0]        last_pad;
  logic [BYTE_W*MAX_REQ-1:0] data_pad;
  logic                      locked;
  logic                      xfer;
  logic                      cap_hit;
  logic                      rel;
  logic                      drop;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .mask  (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    valid_pad                       = '0;
    last_pad                        = '0;
    data_pad                        = '0;
    valid_pad[NUM_REQ-1:0]          = req_valid;
    last_pad[NUM_REQ-1:0]           = req_last;
    data_pad[BYTE_W*NUM_REQ-1:0]    = req_data;
  end

  assign locked   = (state == LOCKED);
  assign busy     = locked;
  assign grant_id = grant;

  // Pure forwarding from the owner; nothing leaves the arbiter in IDLE.
  always_comb begin
    uart_valid = 1'b0;
    uart_data  = '0;
    if (locked) begin
      uart_valid = valid_pad[grant];
      uart_data  = data_pad[{grant, 3'b000} +: BYTE_W];
    end
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = locked && uart_ready && (grant == GRANT_W'(i));
  end

  assign xfer    = locked && uart_valid && uart_ready;
  assign cap_hit = (byte_cnt == CNT_W'(MAX_PKT_BYTES - 1));
  assign rel     = xfer && (last_pad[grant] || cap_hit);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               stall;
  logic               stall_hit;

  // Only ready-but-silent cycles count; a busy UART is not a stall.
  assign stall     = locked && uart_ready && !valid_pad[grant];
  assign stall_hit = stall &&
                     (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));
  assign drop      = rel || stall_hit;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      stall_cnt     <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= stall_hit;
      if (!locked || xfer || stall_hit)
        stall_cnt <= '0;
      else if (stall)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign drop       = rel;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pick_found) state_n = LOCKED;
      LOCKED:  if (drop)       state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      grant    <= '0;
      rr_ptr   <= GRANT_W'(NUM_REQ - 1);
      byte_cnt <= '0;
    end else if (!locked) begin
      if (pick_found) begin
        grant    <= pick_idx;
        byte_cnt <= '0;
      end
    end else if (drop) begin
      rr_ptr   <= grant;
      grant    <= '0;
      byte_cnt <= '0;
    end else if (xfer) begin
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

endmodule
